// File: rtl/data_mem_responder.sv
// Word-addressed data memory responding to single CPU read/write requests with fault detection.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the capture edge; rdata/err are valid with ready.
// No backpressure: one request in flight; inputs are ignored while busy and re-sampled in IDLE.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  waitCnt;
  logic [31:0] capAddr;
  logic [31:0] capWdata;
  logic        capRead;
  logic        capWrite;
  logic [31:0] mem [DEPTH];

  logic          newReq;
  logic          enterResp;
  logic [31:0]   useAddr;
  logic [31:0]   useWdata;
  logic          useRead;
  logic          useWrite;
  logic          useFault;
  logic [AW-1:0] memIdx;

  // Select the live request in IDLE (zero-wait case commits on the capture edge) else the captured one.
  always_comb begin
    newReq    = (state == IDLE) && (mem_read || mem_write);
    useAddr   = capAddr;
    useWdata  = capWdata;
    useRead   = capRead;
    useWrite  = capWrite;
    if (state == IDLE) begin
      useAddr  = addr;
      useWdata = wdata;
      useRead  = mem_read;
      useWrite = mem_write;
    end
    enterResp = (newReq && (WAIT_CYCLES == 0)) || ((state == WAIT) && (waitCnt == 4'd0));
    useFault  = (useAddr[1:0] != 2'b00) || (useAddr[31:2] >= 30'(DEPTH)) || (useRead && useWrite);
    memIdx    = useAddr[AW+1:2];
  end

  assign busy = (state != IDLE);

  // Request FSM: capture in IDLE, count wait states, then one registered ready/err pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      capAddr  <= 32'd0;
      capWdata <= 32'd0;
      capRead  <= 1'b0;
      capWrite <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (newReq) begin
            capAddr  <= addr;
            capWdata <= wdata;
            capRead  <= mem_read;
            capWrite <= mem_write;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state   <= WAIT;
              waitCnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (waitCnt == 4'd0) begin
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          ready <= 1'b1;
          err   <= useFault;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (enterResp && useRead && !useFault) begin
        rdata <= mem[memIdx];
      end
    end
  end

  // Storage array: cleared by reset, written on the edge that enters RESP for a fault-free write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (enterResp && useWrite && !useFault) begin
      mem[memIdx] <= useWdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
// Each scenario task drives requests and compares against hand-computed values.
// Summary line reports comparison and failure counts.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rdata0;
  logic        ready0, busy0, err0;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ready1, busy1, err1;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(rstN), .mem_read(rd0), .mem_write(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(rstN), .mem_read(rd1), .mem_write(wr1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1)
  );

  // Drive one request on the selected instance and collect what it did (no checking here).
  task automatic access(input bit sel, input logic rd, input logic wr, input logic [31:0] ad,
                        input logic [31:0] wd, input bit scramble, output int lat,
                        output logic [31:0] dOut, output logic eOut, output logic busyMid,
                        output logic readyAfter, output logic errLeak);
    lat = -1; dOut = '0; eOut = 1'b0; errLeak = 1'b0;
    @(negedge clk);
    if (sel) begin rd1 = rd; wr1 = wr; addr1 = ad; wdata1 = wd; end
    else     begin rd0 = rd; wr0 = wr; addr0 = ad; wdata0 = wd; end
    @(posedge clk); #1;
    busyMid = sel ? busy1 : busy0;
    if (scramble) begin
      if (sel) begin addr1 = ad ^ 32'h4; wdata1 = ~wd; end
      else     begin addr0 = ad ^ 32'h4; wdata0 = ~wd; end
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sel ? ready1 : ready0) begin
        lat  = i;
        dOut = sel ? rdata1 : rdata0;
        eOut = sel ? err1 : err0;
        break;
      end
      if (sel ? err1 : err0) errLeak = 1'b1;
    end
    if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
    else     begin rd0 = 1'b0; wr0 = 1'b0; end
    @(posedge clk); #1;
    readyAfter = sel ? ready1 : ready0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nChecks++;
    if (rdata0 !== 32'd0 || ready0 !== 1'b0 || busy0 !== 1'b0 || err0 !== 1'b0) begin
      nFail++;
      $display("FAIL reset_dut0: rdata=%h ready=%b busy=%b err=%b, required 0/0/0/0", rdata0, ready0, busy0, err0);
    end
    nChecks++;
    if (rdata1 !== 32'd0 || ready1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0) begin
      nFail++;
      $display("FAIL reset_dut1: rdata=%h ready=%b busy=%b err=%b, required 0/0/0/0", rdata1, ready1, busy1, err1);
    end
    rstN = 1'b1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] d; logic e, bm, ra, el;
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || e !== 1'b0 || bm !== 1'b1 || ra !== 1'b0 || el !== 1'b0) begin
      nFail++;
      $display("FAIL write_0x10: lat=%0d err=%b busy=%b readyAfter=%b errLeak=%b, required 3/0/1/0/0", lat, e, bm, ra, el);
    end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || d !== 32'hDEADBEEF || e !== 1'b0 || ra !== 1'b0) begin
      nFail++;
      $display("FAIL read_0x10: lat=%0d rdata=%h err=%b readyAfter=%b, required 3/deadbeef/0/0", lat, d, e, ra);
    end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] d; logic e, bm, ra, el;
    logic [31:0] expWord;
    int badWords;
    access(0, 1'b1, 1'b0, 32'h102, 32'h0, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'hDEADBEEF) begin
      nFail++;
      $display("FAIL misaligned_read: lat=%0d err=%b rdata=%h, required 3/1/deadbeef", lat, e, d);
    end
    access(0, 1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'hDEADBEEF) begin
      nFail++;
      $display("FAIL range_write: lat=%0d err=%b rdata=%h, required 3/1/deadbeef", lat, e, d);
    end
    badWords = 0;
    for (int w = 0; w < 64; w++) begin
      expWord = (w == 4) ? 32'hDEADBEEF : 32'h0;
      access(0, 1'b1, 1'b0, 32'(w * 4), 32'h0, 0, lat, d, e, bm, ra, el);
      nChecks++;
      if (d !== expWord || e !== 1'b0) begin
        nFail++;
        $display("FAIL mem_scan word %0d: rdata=%h err=%b, required %h/0", w, d, e, expWord);
      end
    end
  endtask

  task automatic test_both_ops();
    int lat; logic [31:0] d; logic e, bm, ra, el;
    access(0, 1'b0, 1'b1, 32'h4, 32'h11112222, 0, lat, d, e, bm, ra, el);
    access(0, 1'b1, 1'b1, 32'h4, 32'h00000099, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      nFail++;
      $display("FAIL rd_and_wr: lat=%0d err=%b rdata=%h, required 3/1/00000000", lat, e, d);
    end
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (d !== 32'h11112222 || e !== 1'b0) begin
      nFail++;
      $display("FAIL word1_kept: rdata=%h err=%b, required 11112222/0", d, e);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] d; logic e, bm, ra, el;
    int pulses;
    @(negedge clk);
    wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h12345678;
    @(posedge clk); #1;
    rstN = 1'b0;
    wr0 = 1'b0;
    #1;
    nChecks++;
    if (busy0 !== 1'b0 || ready0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'd0) begin
      nFail++;
      $display("FAIL async_reset: busy=%b ready=%b err=%b rdata=%h, required 0/0/0/0", busy0, ready0, err0, rdata0);
    end
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready0) pulses++;
    end
    rstN = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready0) pulses++;
    end
    nChecks++;
    if (pulses !== 0) begin
      nFail++;
      $display("FAIL abort_no_ready: ready pulses=%0d, required 0", pulses);
    end
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || d !== 32'h0 || e !== 1'b0) begin
      nFail++;
      $display("FAIL aborted_write: lat=%0d rdata=%h err=%b, required 3/00000000/0", lat, d, e);
    end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (d !== 32'h0) begin
      nFail++;
      $display("FAIL mem_cleared: rdata=%h, required 00000000", d);
    end
  endtask

  task automatic test_first_edge_after_reset();
    int lat; logic [31:0] d; logic e, bm, ra, el;
    @(posedge clk); #1;
    rstN = 1'b0;
    #3;
    rstN = 1'b1;
    access(0, 1'b0, 1'b1, 32'h3C, 32'h0BADC0DE, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || e !== 1'b0 || bm !== 1'b1) begin
      nFail++;
      $display("FAIL first_edge_capture: lat=%0d err=%b busy=%b, required 3/0/1", lat, e, bm);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e, bm, ra, el;
    logic [31:0] vals [4];
    vals[0] = 32'hA0A0A0A0; vals[1] = 32'hB1B1B1B1; vals[2] = 32'hC2C2C2C2; vals[3] = 32'hD3D3D3D3;
    for (int k = 0; k < 4; k++) begin
      access(1, 1'b0, 1'b1, 32'(k * 4), vals[k], 0, lat, d, e, bm, ra, el);
      nChecks++;
      if (lat !== 1 || e !== 1'b0 || bm !== 1'b1 || ra !== 1'b0) begin
        nFail++;
        $display("FAIL b2b_write %0d: lat=%0d err=%b busy=%b readyAfter=%b, required 1/0/1/0", k, lat, e, bm, ra);
      end
    end
    for (int k = 0; k < 4; k++) begin
      access(1, 1'b1, 1'b0, 32'(k * 4), 32'h0, 0, lat, d, e, bm, ra, el);
      nChecks++;
      if (lat !== 1 || d !== vals[k] || e !== 1'b0) begin
        nFail++;
        $display("FAIL b2b_read %0d: lat=%0d rdata=%h err=%b, required 1/%h/0", k, lat, d, e, vals[k]);
      end
    end
    access(1, 1'b1, 1'b0, 32'h41, 32'h0, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 1 || e !== 1'b1 || d !== vals[3]) begin
      nFail++;
      $display("FAIL nowait_fault: lat=%0d err=%b rdata=%h, required 1/1/%h", lat, e, d, vals[3]);
    end
  endtask

  task automatic test_input_change();
    int lat; logic [31:0] d; logic e, bm, ra, el;
    access(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1, lat, d, e, bm, ra, el);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1, lat, d, e, bm, ra, el);
    nChecks++;
    if (lat !== 3 || d !== 32'hA5A5A5A5 || e !== 1'b0) begin
      nFail++;
      $display("FAIL captured_only: lat=%0d rdata=%h err=%b, required 3/a5a5a5a5/0", lat, d, e);
    end
    access(0, 1'b1, 1'b0, 32'h24, 32'h0, 0, lat, d, e, bm, ra, el);
    nChecks++;
    if (d !== 32'h0) begin
      nFail++;
      $display("FAIL neighbour_untouched: rdata=%h, required 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_faults();
    test_both_ops();
    test_reset_abort();
    test_first_edge_after_reset();
    test_back_to_back();
    test_input_change();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
